// File: rtl/jpeg_pkg.sv
// jpeg_pkg: types and constants shared by the dequantizer, the transpose
// buffer and the IDCT stages.
//   COEF_W  coefficient width (two's complement)
//   BLK_N   block dimension (fixed at 8)
//   coef_t  one signed coefficient
//   row_t   BLK_N packed coefficients; element 0 sits in the MSBs
//   idx_t   row/column index inside a block
package jpeg_pkg;

  localparam int COEF_W = 12;
  localparam int BLK_N  = 8;
  localparam int IDX_W  = 3;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef coef_t [BLK_N-1:0]        row_t;
  typedef logic [IDX_W-1:0]         idx_t;

  localparam idx_t IDX_LAST = 3'd7;

endpackage : jpeg_pkg

// File: rtl/tbuf_bank.sv
// tbuf_bank: one 8x8 coefficient bank of the transpose buffer.
// A whole row is written per cycle; a whole column is read combinationally.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (clears the bank)
//   we_i         write enable for wr_row_i into row wr_idx_i
//   wr_idx_i     destination row index
//   wr_row_i     row data, element 0 in the MSBs
//   rd_col_i     column index to read
//   rd_col_o     column data, row 0 in the MSBs
module tbuf_bank
  import jpeg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic we_i,
  input  idx_t wr_idx_i,
  input  row_t wr_row_i,
  input  idx_t rd_col_i,
  output row_t rd_col_o
);

  // mem_q[r][c] holds block element (row r, column c)
  coef_t mem_q [BLK_N][BLK_N];

  // Row write port; bank contents are cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < BLK_N; r++) begin
        for (int c = 0; c < BLK_N; c++) begin
          mem_q[r][c] <= '0;
        end
      end
    end else if (we_i) begin
      // element c of the incoming row lives at packed position BLK_N-1-c
      for (int c = 0; c < BLK_N; c++) begin
        mem_q[wr_idx_i][c] <= wr_row_i[BLK_N-1-c];
      end
    end
  end

  // Column read mux: row r of the selected column goes to packed slot BLK_N-1-r
  always_comb begin
    rd_col_o = '0;
    for (int r = 0; r < BLK_N; r++) begin
      rd_col_o[BLK_N-1-r] = mem_q[r][rd_col_i];
    end
  end

endmodule : tbuf_bank

// File: rtl/dequant_transpose_buf.sv
// dequant_transpose_buf: ping-pong 8x8 transpose buffer between the
// dequantizer and the column pass of the IDCT. Rows are written into one
// bank while the other bank is read out column by column.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid_i      in_row_i carries a valid row
//   in_ready_o      a row can be accepted this cycle
//   in_row_i        row coefficients, element 0 in the MSBs
//   wr_row_o        row index the next accepted row will occupy
//   out_valid_o     out_col_o carries a valid column
//   out_ready_i     downstream accepts the column
//   out_col_o       column, row 0 in the MSBs
//   out_col_idx_o   index of the column on out_col_o
//   out_last_o      last column of the block is on the output
// All outputs depend on registered state only.
module dequant_transpose_buf
  import jpeg_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  row_t in_row_i,
  output idx_t wr_row_o,
  output logic out_valid_o,
  input  logic out_ready_i,
  output row_t out_col_o,
  output idx_t out_col_idx_o,
  output logic out_last_o
);

  logic [1:0] full_q, full_d;
  logic       wsel_q, wsel_d;
  logic       rsel_q, rsel_d;
  idx_t       wrow_q, wrow_d;
  idx_t       rcol_q, rcol_d;

  logic       wr_fire_s;
  logic       rd_fire_s;
  logic       we0_s, we1_s;
  row_t       col0_s, col1_s;

  // Handshake qualifiers and per-bank write enables
  always_comb begin
    in_ready_o  = ~full_q[wsel_q];
    out_valid_o = full_q[rsel_q];
    wr_fire_s   = in_valid_i & in_ready_o;
    rd_fire_s   = out_valid_o & out_ready_i;
    we0_s       = wr_fire_s & ~wsel_q;
    we1_s       = wr_fire_s & wsel_q;
  end

  tbuf_bank u_bank0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we0_s),
    .wr_idx_i (wrow_q),
    .wr_row_i (in_row_i),
    .rd_col_i (rcol_q),
    .rd_col_o (col0_s)
  );

  tbuf_bank u_bank1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (we1_s),
    .wr_idx_i (wrow_q),
    .wr_row_i (in_row_i),
    .rd_col_i (rcol_q),
    .rd_col_o (col1_s)
  );

  // Next-state for pointers and full flags. A write completion and a read
  // completion in the same cycle always hit different banks, so both
  // flag updates can be applied independently.
  always_comb begin
    full_d = full_q;
    wsel_d = wsel_q;
    wrow_d = wrow_q;
    rsel_d = rsel_q;
    rcol_d = rcol_q;
    if (wr_fire_s) begin
      wrow_d = wrow_q + 3'd1;
      if (wrow_q == IDX_LAST) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end else begin
        full_d[wsel_q] = full_q[wsel_q];
      end
    end else begin
      wrow_d = wrow_q;
    end
    if (rd_fire_s) begin
      rcol_d = rcol_q + 3'd1;
      if (rcol_q == IDX_LAST) begin
        full_d[rsel_q] = 1'b0;
        rsel_d         = ~rsel_q;
      end else begin
        full_d[rsel_q] = full_d[rsel_q];
      end
    end else begin
      rcol_d = rcol_q;
    end
  end

  // Pointer and full-flag registers; reset discards any partial block
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 2'b00;
      wsel_q <= 1'b0;
      wrow_q <= 3'd0;
      rsel_q <= 1'b0;
      rcol_q <= 3'd0;
    end else begin
      full_q <= full_d;
      wsel_q <= wsel_d;
      wrow_q <= wrow_d;
      rsel_q <= rsel_d;
      rcol_q <= rcol_d;
    end
  end

  // Read-side bank select and status outputs
  always_comb begin
    if (rsel_q) begin
      out_col_o = col1_s;
    end else begin
      out_col_o = col0_s;
    end
    wr_row_o      = wrow_q;
    out_col_idx_o = rcol_q;
    out_last_o    = out_valid_o & (rcol_q == IDX_LAST);
  end

endmodule : dequant_transpose_buf

// File: tb/tb_dequant_transpose_buf.sv
// Self-checking bench for dequant_transpose_buf. Expected columns are
// pushed to a scoreboard queue as each block's 8th row is accepted and
// popped when the design hands a column over.
module tb_dequant_transpose_buf;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_row;
  logic [2:0]  wr_row;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_col;
  logic [2:0]  out_col_idx;
  logic        out_last;

  logic [98:0] q [$];        // {column index, column data}
  logic [95:0] blk_rows [8];
  int          m_wrow;
  int          g_row;
  int          n_pass;
  int          n_total;

  dequant_transpose_buf dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_row_i      (in_row),
    .wr_row_o      (wr_row),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_col_o     (out_col),
    .out_col_idx_o (out_col_idx),
    .out_last_o    (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [95:0] gen_row(input int mode, input int idx);
    logic [95:0] r;
    logic [11:0] v;
    logic [11:0] ext [4];
    int blk;
    int rr;
    blk = idx / 8;
    rr  = idx % 8;
    ext[0] = 12'h800;
    ext[1] = 12'h7FF;
    ext[2] = 12'hFFF;
    ext[3] = 12'h000;
    r = '0;
    for (int c = 0; c < 8; c++) begin
      case (mode)
        0:       v = 12'(16 * rr + c + 128 * blk);
        1:       v = ext[(rr * 3 + c + blk) % 4];
        default: v = 12'($urandom);
      endcase
      r[95 - 12 * c -: 12] = v;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_row = '0;
    q.delete();
    m_wrow = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", out_last); else n_pass++;
    n_total++; if (wr_row !== 3'd0) $display("FAIL reset_wr_row got %0d want 0", wr_row); else n_pass++;
    n_total++; if (out_col_idx !== 3'd0) $display("FAIL reset_col_idx got %0d want 0", out_col_idx); else n_pass++;
    n_total++; if (out_col !== 96'd0) $display("FAIL reset_out_col got %h want 0", out_col); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Drives nrows rows and accepts nbeats columns, checking every cycle.
  task automatic run_stream(input string tag, input int nrows, input int nbeats, input int mode,
                            input int vpct, input int rpct, input bit chk_rdy, input bit chk_nobub);
    int rows_sent;
    int beats;
    int cyc;
    int budget;
    int nfull;
    bit held;
    bit started;
    logic [95:0] prev_col;
    logic [95:0] col;
    logic [98:0] ent;
    rows_sent = 0;
    beats = 0;
    cyc = 0;
    held = 1'b0;
    started = 1'b0;
    prev_col = '0;
    budget = (nrows + nbeats) * 20 + 100;
    while ((rows_sent < nrows || beats < nbeats) && cyc < budget) begin
      in_valid  = (rows_sent < nrows) && ($urandom_range(99) < vpct);
      in_row    = gen_row(mode, g_row);
      out_ready = (beats < nbeats) && ($urandom_range(99) < rpct);
      @(negedge clk);
      nfull = (q.size() + 7) / 8;
      n_total++; if (out_valid !== (q.size() != 0)) $display("FAIL %s out_valid got %b want %b", tag, out_valid, q.size() != 0); else n_pass++;
      n_total++; if (in_ready !== (nfull < 2)) $display("FAIL %s in_ready got %b want %b", tag, in_ready, nfull < 2); else n_pass++;
      if (held) begin
        n_total++; if (out_col !== prev_col) $display("FAIL %s hold_col got %h want %h", tag, out_col, prev_col); else n_pass++;
      end
      if (chk_nobub && started && beats < nbeats) begin
        n_total++; if (out_valid !== 1'b1) $display("FAIL %s bubble out_valid got %b want 1", tag, out_valid); else n_pass++;
      end
      if (out_valid && q.size() != 0) begin
        ent = q[0];
        n_total++; if (out_col_idx !== ent[98:96]) $display("FAIL %s col_idx got %0d want %0d", tag, out_col_idx, ent[98:96]); else n_pass++;
        n_total++; if (out_last !== (ent[98:96] == 3'd7)) $display("FAIL %s out_last got %b want %b", tag, out_last, ent[98:96] == 3'd7); else n_pass++;
      end
      if (chk_rdy && in_valid) begin
        n_total++; if (in_ready !== 1'b1) $display("FAIL %s stream_in_ready got %b want 1", tag, in_ready); else n_pass++;
      end
      if (in_valid && in_ready) begin
        n_total++; if (wr_row !== 3'(m_wrow)) $display("FAIL %s wr_row got %0d want %0d", tag, wr_row, m_wrow); else n_pass++;
        blk_rows[m_wrow] = in_row;
        if (m_wrow == 7) begin
          for (int c = 0; c < 8; c++) begin
            col = '0;
            for (int r = 0; r < 8; r++) begin
              col[95 - 12 * r -: 12] = blk_rows[r][95 - 12 * c -: 12];
            end
            q.push_back({3'(c), col});
          end
        end
        m_wrow = (m_wrow + 1) % 8;
        rows_sent++;
        g_row++;
      end
      if (out_valid && out_ready && q.size() != 0) begin
        ent = q.pop_front();
        n_total++; if (out_col !== ent[95:0]) $display("FAIL %s out_col got %h want %h", tag, out_col, ent[95:0]); else n_pass++;
        beats++;
        started = 1'b1;
      end
      held = out_valid && !out_ready;
      prev_col = out_col;
      @(posedge clk);
      #1;
      cyc++;
    end
    n_total++;
    if (rows_sent < nrows || beats < nbeats)
      $display("FAIL %s timeout rows %0d/%0d beats %0d/%0d", tag, rows_sent, nrows, beats, nbeats);
    else
      n_pass++;
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_single_block();
    run_stream("single", 8, 8, 0, 100, 100, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_stream("stream", 24, 24, 0, 100, 100, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure();
    run_stream("bp_fill", 16, 0, 2, 100, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_row    = gen_row(2, g_row);
      out_ready = 1'b0;
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL bp_stall in_ready got %b want 0", in_ready); else n_pass++;
      n_total++; if (out_valid !== 1'b1) $display("FAIL bp_stall out_valid got %b want 1", out_valid); else n_pass++;
      n_total++; if (out_col !== q[0][95:0]) $display("FAIL bp_stall out_col got %h want %h", out_col, q[0][95:0]); else n_pass++;
      n_total++; if (wr_row !== 3'(m_wrow)) $display("FAIL bp_stall wr_row got %0d want %0d", wr_row, m_wrow); else n_pass++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    run_stream("bp_drain", 0, 16, 2, 100, 100, 1'b0, 1'b1);
  endtask

  task automatic test_extremes();
    run_stream("extremes", 16, 16, 1, 100, 100, 1'b0, 1'b0);
  endtask

  task automatic test_random_stalls();
    run_stream("random", 800, 800, 2, 50, 50, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    run_stream("rm_pre", 14, 3, 2, 100, 100, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rm in_ready got %b want 1", in_ready); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rm out_valid got %b want 0", out_valid); else n_pass++;
    n_total++; if (out_last !== 1'b0) $display("FAIL rm out_last got %b want 0", out_last); else n_pass++;
    n_total++; if (wr_row !== 3'd0) $display("FAIL rm wr_row got %0d want 0", wr_row); else n_pass++;
    n_total++; if (out_col_idx !== 3'd0) $display("FAIL rm col_idx got %0d want 0", out_col_idx); else n_pass++;
    n_total++; if (out_col !== 96'd0) $display("FAIL rm out_col got %h want 0", out_col); else n_pass++;
    q.delete();
    m_wrow = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_stream("rm_post", 8, 8, 0, 100, 100, 1'b1, 1'b1);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    g_row = 0;
    m_wrow = 0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_row = '0;
    rst_n = 1'b0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_extremes();
    test_random_stalls();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_dequant_transpose_buf

// File: doc/dequant_transpose_buf.md
# dequant_transpose_buf

Double-buffered 8×8 transpose buffer between dequantization and the column pass of the 2-D IDCT. Accepts one row of eight 12-bit dequantized coefficients per handshake, stores a full 8×8 block, then emits it one column per handshake. Two banks in ping-pong let block N+1 be written while block N is read, sustaining one row in and one column out per cycle.

## Interface
- COEF_W, 12, coefficient width (two's complement)
- BLK_N, 8, block dimension; fixed at 8, other values unsupported
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_row carries a valid row
- in_ready  out  1  buffer can accept a row this cycle
- in_row  in  BLK_N*COEF_W  row coefficients; element 0 in MSBs `[95:84]`, element 7 in LSBs `[11:0]`
- wr_row  out  3  row index the next accepted row will occupy (0..7)
- out_valid  out  1  out_col carries a valid column
- out_ready  in  1  downstream accepts the column
- out_col  out  BLK_N*COEF_W  column; element r = row r of the block, row 0 in MSBs
- out_col_idx  out  3  index of the column on out_col (0..7)
- out_last  out  1  out_valid and out_col_idx==7

## Operation
- State:
  - banks B0/B1, each 64×COEF_W registers
  - full[1:0]
  - wsel, wrow[2:0]
  - rsel, rcol[2:0]
- Write side:
  - in_ready = !full[wsel].
  - On in_valid && in_ready: B[wsel][wrow] <= in_row; wrow++.
  - If wrow was 7: full[wsel] <= 1, wsel toggles, wrow wraps to 0.
- Read side:
  - out_valid = full[rsel].
  - out_col = {B[rsel][0][rcol], …, B[rsel][7][rcol]}.
  - On out_valid && out_ready: rcol++.
  - If rcol was 7: full[rsel] <= 0, rsel toggles, rcol wraps to 0.
- wr_row = wrow. out_col_idx = rcol.
- Coefficients pass bit-exact. No arithmetic, saturation or sign change.
- Simultaneous events:
  - Write completion and read completion in the same cycle always target different banks. Both take effect.
  - Writes only go to empty banks and reads only come from full banks, so no bank is ever read and written in the same cycle.
- Full: both banks full → in_ready=0 until the read of rsel finishes. Rows are never dropped or overwritten.
- Empty: both banks empty → out_valid=0, and out_col holds its last mux value (don't care).
- Protocol:
  - out_valid never drops without a handshake.
  - out_col is stable while out_valid && !out_ready.
  - in_row is sampled only on handshake.
- Reset mid-block: every partially written or partially read block is discarded. Both banks go empty, and the next accepted row is row 0 of bank 0.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_last=0
  - wr_row=0, out_col_idx=0, out_col=0
  - banks cleared to 0; all pointers 0
- Latency: 8th row accepted at edge k → out_valid=1 in the cycle after edge k, column 0 available immediately.
- Throughput:
  - 1 row/cycle in, 1 column/cycle out.
  - Back-to-back blocks run with no bubble when out_ready is held high.
- in_ready, out_valid, out_col and out_last are combinational from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- jpeg_pkg holds:
  - COEF_W, BLK_N
  - typedef coef_t (signed COEF_W)
  - typedef row_t (BLK_N×coef_t packed)
  - typedef idx_t (3-bit)
  - shared with the dequantizer and IDCT stages
- Sub-module tbuf_bank, instantiated twice:
  - 8×8 coef_t register array with a row-write port (we, row idx, row_t)
  - one column-read mux (col idx → row_t)
- The top level holds the handshake, pointers and full flags, and a 2:1 bank select on the read column.

## Test plan
- **Single block.** Send 8 rows with element (r,c) = 16r+c, out_ready=1 → out_valid rises the cycle after the 8th row. Column c elements are c, 16+c, …, 112+c. out_last is asserted only with out_col_idx=7.
- **Streaming.** Send 3 consecutive blocks with in_valid and out_ready held at 1 → in_ready is never low. Outputs are 24 consecutive column beats in order, with no bubble after the first.
- **Backpressure.** Hold out_ready=0 and send 16 rows → in_ready drops after row 16. A 17th in_valid is stalled. The first column is held stable throughout. Releasing out_ready drains block 0, then block 1.
- **Sign and extremes.** Rows containing 12'h800, 12'h7FF, 12'hFFF and 0 → the same bit patterns appear at the transposed positions.
- **Random stalls.** Random in_valid/out_ready at 50% over 100 blocks → a scoreboard transpose matches exactly, and wr_row/out_col_idx sequences are monotonic mod 8.
- **Reset mid-operation.** Assert rst_n=0 asynchronously after row 5 of block 1, while block 0 is at column 3 → all outputs go to reset values immediately. After release, a fresh block is emitted correctly, with no residue of earlier data.
